// File: rtl/life_pkg.sv
// Shared definitions for the Conway step engine.
//   DEF_WIDTH / DEF_HEIGHT : default field geometry (columns x rows)
//   DEF_POP_W              : population counter width for the default field
//   life_state_t           : step FSM states
//   nbr_cnt_t              : neighbour count, 0..8
package life_pkg;

    localparam int DEF_WIDTH  = 40;
    localparam int DEF_HEIGHT = 30;
    localparam int DEF_POP_W  = $clog2(DEF_WIDTH * DEF_HEIGHT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } life_state_t;

    typedef logic [3:0] nbr_cnt_t;

endpackage

// File: rtl/life_row_rule.sv
// Combinational next-generation rule for one row.
//   row_above / row_cur / row_below : the three source rows (bit index = column)
//   row_next                        : next generation of row_cur
//   row_pop                         : number of live cells in row_next
// WRAP=1 joins column 0 and column WIDTH-1; WRAP=0 treats outside columns as dead.
// Vertical edge handling is the caller's job (it chooses the above/below rows).
module life_row_rule
    import life_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WRAP  = 1
) (
    input  logic [WIDTH-1:0]               row_above,
    input  logic [WIDTH-1:0]               row_cur,
    input  logic [WIDTH-1:0]               row_below,
    output logic [WIDTH-1:0]               row_next,
    output logic [$clog2(WIDTH+1)-1:0]     row_pop
);

    localparam int RP_W = $clog2(WIDTH + 1);

    nbr_cnt_t n;
    int       cc;
    logic     in_range;
    logic     alive;

    always_comb begin
        row_next = '0;
        row_pop  = '0;
        n        = '0;
        cc       = 0;
        in_range = 1'b0;
        alive    = 1'b0;
        for (int c = 0; c < WIDTH; c++) begin
            n = '0;
            for (int dc = -1; dc <= 1; dc++) begin
                cc       = c + dc;
                in_range = 1'b1;
                if (cc < 0) begin
                    cc       = WIDTH - 1;
                    in_range = (WRAP != 0);
                end else if (cc >= WIDTH) begin
                    cc       = 0;
                    in_range = (WRAP != 0);
                end
                if (in_range) begin
                    n = n + nbr_cnt_t'(row_above[cc]) + nbr_cnt_t'(row_below[cc]);
                    // The centre cell itself is not its own neighbour.
                    if (dc != 0) begin
                        n = n + nbr_cnt_t'(row_cur[cc]);
                    end
                end
            end
            alive       = (n == nbr_cnt_t'(3)) || (row_cur[c] && (n == nbr_cnt_t'(2)));
            row_next[c] = alive;
            row_pop     = row_pop + RP_W'(alive);
        end
    end

endmodule

// File: rtl/life_step_engine.sv
// Conway step engine: snapshots the field on start, then produces one next-gen
// row per clock into field_next, followed by a one-cycle valid strobe.
//   clk, rst (sync, active-low)
//   start          : step request pulse (dropped while busy)
//   field_in       : current field, HEIGHT rows of WIDTH bits
//   field_next     : registered next generation
//   field_next_vld : one-cycle strobe, field_next complete
//   busy           : step in progress (start edge through DONE cycle)
//   population     : live cells in field_next, updated with vld
//   generation     : completed-step counter, updated with vld
//   state_dbg      : current FSM state
// Handshake: start is a request pulse honoured only when busy=0; field_next_vld
// is a pure strobe with no back-pressure.
module life_step_engine
    import life_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WRAP   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [WIDTH-1:0]                      field_in [HEIGHT],
    output logic [WIDTH-1:0]                      field_next [HEIGHT],
    output logic                                  field_next_vld,
    output logic                                  busy,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]     population,
    output logic [15:0]                           generation,
    output life_state_t                           state_dbg
);

    localparam int POP_W = $clog2(WIDTH * HEIGHT + 1);
    localparam int RP_W  = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    life_state_t        state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [POP_W-1:0]   acc_q, acc_d;
    logic [POP_W-1:0]   pop_q, pop_d;
    logic [15:0]        gen_q, gen_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   snap_q [HEIGHT];
    logic [WIDTH-1:0]   snap_d [HEIGHT];
    logic [WIDTH-1:0]   fn_q   [HEIGHT];
    logic [WIDTH-1:0]   fn_d   [HEIGHT];

    logic [WIDTH-1:0]   above_row, cur_row, below_row, rule_row;
    logic [RP_W-1:0]    rule_pop;

    // Vertical neighbours of the current row; edges wrap or read as dead.
    always_comb begin
        above_row = '0;
        below_row = '0;
        cur_row   = snap_q[row_q];
        if (row_q == '0) begin
            if (WRAP != 0) above_row = snap_q[HEIGHT-1];
        end else begin
            above_row = snap_q[row_q - ROW_W'(1)];
        end
        if (row_q >= LAST_ROW) begin
            if (WRAP != 0) below_row = snap_q[0];
        end else begin
            below_row = snap_q[row_q + ROW_W'(1)];
        end
    end

    life_row_rule #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_rule (
        .row_above (above_row),
        .row_cur   (cur_row),
        .row_below (below_row),
        .row_next  (rule_row),
        .row_pop   (rule_pop)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        acc_d   = acc_q;
        pop_d   = pop_q;
        gen_d   = gen_q;
        vld_d   = 1'b0;
        snap_d  = snap_q;
        fn_d    = fn_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d  = field_in;
                    row_d   = '0;
                    acc_d   = '0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                fn_d[row_q] = rule_row;
                acc_d       = acc_q + POP_W'(rule_pop);
                row_d       = row_q + ROW_W'(1);
                if (row_q == LAST_ROW) state_d = ST_DONE;
            end
            ST_DONE: begin
                vld_d   = 1'b1;
                pop_d   = acc_q;
                gen_d   = gen_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered busy mirrors the state being entered, so it is high
        // from the start edge through the DONE cycle.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            acc_q   <= '0;
            pop_q   <= '0;
            gen_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int r = 0; r < HEIGHT; r++) begin
                snap_q[r] <= '0;
                fn_q[r]   <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            pop_q   <= pop_d;
            gen_q   <= gen_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            for (int r = 0; r < HEIGHT; r++) begin
                snap_q[r] <= snap_d[r];
                fn_q[r]   <= fn_d[r];
            end
        end
    end

    assign field_next     = fn_q;
    assign field_next_vld = vld_q;
    assign busy           = busy_q;
    assign population     = pop_q;
    assign generation     = gen_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: one toroidal and one bounded instance share the
// same stimulus; a cell-level Life model predicts both results.
module tb_life_step_engine;
    import life_pkg::*;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int PW  = $clog2(W * H + 1);
    localparam int LAT = H + 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic start;
    logic [W-1:0] fin [H];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  fn_w [H];
    logic [W-1:0]  fn_n [H];
    logic          vld_w, vld_n, busy_w, busy_n;
    logic [PW-1:0] pop_w, pop_n;
    logic [15:0]   gen_w, gen_n;
    life_state_t   st_w, st_n;

    life_step_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .start(start), .field_in(fin),
        .field_next(fn_w), .field_next_vld(vld_w), .busy(busy_w),
        .population(pop_w), .generation(gen_w), .state_dbg(st_w)
    );

    life_step_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0)) dut_n (
        .clk(clk), .rst(rst), .start(start), .field_in(fin),
        .field_next(fn_n), .field_next_vld(vld_n), .busy(busy_n),
        .population(pop_n), .generation(gen_n), .state_dbg(st_n)
    );

    // ---------------- reference model ----------------
    logic [W-1:0]  exp_w [H];
    logic [W-1:0]  exp_n [H];
    logic [W-1:0]  pat   [H];
    logic [PW-1:0] epop_w, epop_n;
    logic [15:0]   exp_gen;
    int n_cmp;
    int n_err;

    function automatic int cell_at(int r, int c, int wrap);
        if (wrap != 0) begin
            r = (r + H) % H;
            c = (c + W) % W;
        end else if (r < 0 || r >= H || c < 0 || c >= W) begin
            return 0;
        end
        return int'(fin[r][c]);
    endfunction

    task automatic ref_step();
        int nw, nn, sw, sn;
        sw = 0;
        sn = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                nw = 0;
                nn = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            nw += cell_at(r + dr, c + dc, 1);
                            nn += cell_at(r + dr, c + dc, 0);
                        end
                    end
                end
                exp_w[r][c] = (nw == 3) || (fin[r][c] == 1'b1 && nw == 2);
                exp_n[r][c] = (nn == 3) || (fin[r][c] == 1'b1 && nn == 2);
                sw += int'(exp_w[r][c]);
                sn += int'(exp_n[r][c]);
            end
        end
        epop_w = PW'(sw);
        epop_n = PW'(sn);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fin();
        for (int r = 0; r < H; r++) fin[r] = '0;
    endtask

    task automatic rand_fin();
        for (int r = 0; r < H; r++)
            fin[r] = W'({$urandom(), $urandom()} & {$urandom(), $urandom()});
    endtask

    // Glider (down-right moving) with its 3x3 box top-left at (r0,c0), torus.
    task automatic place_glider(int r0, int c0);
        int gr[5];
        int gc[5];
        gr = '{0, 1, 2, 2, 2};
        gc = '{1, 2, 0, 1, 2};
        for (int r = 0; r < H; r++) pat[r] = '0;
        for (int k = 0; k < 5; k++) pat[(r0 + gr[k]) % H][(c0 + gc[k]) % W] = 1'b1;
    endtask

    // Snapshot model from fin, pulse start, wait (bounded) for vld.
    task automatic do_step(output int lat);
        ref_step();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (vld_w !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        exp_gen++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        rand_fin();
        repeat (3) tick();
        n_cmp++;
        if ({vld_w, vld_n, busy_w, busy_n} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: vld/busy = %b, want 0000", {vld_w, vld_n, busy_w, busy_n});
        end
        n_cmp++;
        if (pop_w !== '0 || pop_n !== '0 || gen_w !== 16'd0 || gen_n !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counts: pop %0d/%0d gen %0d/%0d, want 0", pop_w, pop_n, gen_w, gen_n);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== '0 || fn_n[r] !== '0) begin
                n_err++;
                $display("FAIL reset_row%0d: got %h/%h, want 0", r, fn_w[r], fn_n[r]);
            end
        end
        rst = 1'b1;
        exp_gen = 16'd0;
        tick();
    endtask

    task automatic test_blinker();
        int lat;
        logic [W-1:0] orig [H];
        clear_fin();
        fin[5][12:10] = 3'b111;
        orig = fin;
        do_step(lat);
        n_cmp++;
        if (lat !== LAT || vld_n !== 1'b1) begin
            n_err++;
            $display("FAIL blinker_latency: got %0d (nowrap vld %b), want %0d", lat, vld_n, LAT);
        end
        n_cmp++;
        if (busy_w !== 1'b0) begin
            n_err++;
            $display("FAIL blinker_busy_at_vld: got %b, want 0", busy_w);
        end
        n_cmp++;
        if (pop_w !== PW'(3) || gen_w !== 16'd1 || gen_n !== 16'd1) begin
            n_err++;
            $display("FAIL blinker_counts: pop %0d gen %0d/%0d, want 3 gen 1", pop_w, gen_w, gen_n);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== exp_w[r] || fn_n[r] !== exp_n[r] ||
                fn_w[r] !== ((r >= 4 && r <= 6) ? W'(1) << 11 : W'(0))) begin
                n_err++;
                $display("FAIL blinker_row%0d: got %h/%h, want %h/%h", r, fn_w[r], fn_n[r], exp_w[r], exp_n[r]);
            end
        end
        fin = exp_w;
        do_step(lat);
        n_cmp++;
        if (lat !== LAT || gen_w !== 16'd2 || pop_w !== PW'(3)) begin
            n_err++;
            $display("FAIL blinker2_counts: lat %0d gen %0d pop %0d, want %0d 2 3", lat, gen_w, pop_w, LAT);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== orig[r] || fn_n[r] !== exp_n[r]) begin
                n_err++;
                $display("FAIL blinker2_row%0d: got %h/%h, want %h/%h", r, fn_w[r], fn_n[r], orig[r], exp_n[r]);
            end
        end
        tick();
        n_cmp++;
        if (vld_w !== 1'b0 || vld_n !== 1'b0) begin
            n_err++;
            $display("FAIL blinker_vld_width: vld %b/%b one cycle later, want 0", vld_w, vld_n);
        end
    endtask

    task automatic test_block();
        int lat;
        clear_fin();
        fin[8][21:20] = 2'b11;
        fin[9][21:20] = 2'b11;
        do_step(lat);
        n_cmp++;
        if (lat !== LAT || pop_w !== PW'(4) || pop_n !== PW'(4) || gen_w !== exp_gen) begin
            n_err++;
            $display("FAIL block_counts: lat %0d pop %0d/%0d gen %0d, want %0d 4 %0d", lat, pop_w, pop_n, gen_w, LAT, exp_gen);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== fin[r] || fn_n[r] !== fin[r]) begin
                n_err++;
                $display("FAIL block_row%0d: got %h/%h, want %h", r, fn_w[r], fn_n[r], fin[r]);
            end
        end
    endtask

    task automatic test_all_ones();
        int lat;
        for (int r = 0; r < H; r++) fin[r] = '1;
        do_step(lat);
        n_cmp++;
        if (lat !== LAT || pop_w !== PW'(0) || pop_n !== PW'(4) || epop_n !== PW'(4)) begin
            n_err++;
            $display("FAIL ones_counts: lat %0d pop wrap %0d nowrap %0d, want %0d 0 4", lat, pop_w, pop_n, LAT);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== '0 || fn_n[r] !== exp_n[r] ||
                fn_n[r] !== ((r == 0 || r == H - 1) ? {1'b1, {(W-2){1'b0}}, 1'b1} : W'(0))) begin
                n_err++;
                $display("FAIL ones_row%0d: got %h/%h, want 0/%h", r, fn_w[r], fn_n[r], exp_n[r]);
            end
        end
    endtask

    task automatic test_glider();
        int lat;
        place_glider(28, 39);
        fin = pat;
        for (int k = 1; k <= 4; k++) begin
            do_step(lat);
            n_cmp++;
            if (lat !== LAT || pop_w !== PW'(5) || pop_n !== epop_n || gen_w !== exp_gen) begin
                n_err++;
                $display("FAIL glider_step%0d_counts: lat %0d pop %0d/%0d gen %0d, want %0d 5/%0d %0d",
                         k, lat, pop_w, pop_n, gen_w, LAT, epop_n, exp_gen);
            end
            for (int r = 0; r < H; r++) begin
                n_cmp++;
                if (fn_w[r] !== exp_w[r] || fn_n[r] !== exp_n[r]) begin
                    n_err++;
                    $display("FAIL glider_step%0d_row%0d: got %h/%h, want %h/%h", k, r, fn_w[r], fn_n[r], exp_w[r], exp_n[r]);
                end
            end
            fin = exp_w;
        end
        place_glider(29, 0);
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== pat[r]) begin
                n_err++;
                $display("FAIL glider_translated_row%0d: got %h, want %h", r, fn_w[r], pat[r]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 4; t++) begin
            rand_fin();
            do_step(lat);
            n_cmp++;
            if (lat !== LAT || pop_w !== epop_w || pop_n !== epop_n || gen_w !== exp_gen || gen_n !== exp_gen) begin
                n_err++;
                $display("FAIL random%0d_counts: lat %0d pop %0d/%0d gen %0d/%0d, want %0d %0d/%0d %0d",
                         t, lat, pop_w, pop_n, gen_w, gen_n, LAT, epop_w, epop_n, exp_gen);
            end
            for (int r = 0; r < H; r++) begin
                n_cmp++;
                if (fn_w[r] !== exp_w[r] || fn_n[r] !== exp_n[r]) begin
                    n_err++;
                    $display("FAIL random%0d_row%0d: got %h/%h, want %h/%h", t, r, fn_w[r], fn_n[r], exp_w[r], exp_n[r]);
                end
            end
        end
    endtask

    task automatic test_start_busy();
        int n_vld, first;
        rand_fin();
        ref_step();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_gen++;
        n_vld = 0;
        first = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 3) rand_fin();
            if (k == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (vld_w === 1'b1 || vld_n === 1'b1) begin
                n_vld++;
                if (n_vld == 1) begin
                    first = k;
                    for (int r = 0; r < H; r++) begin
                        n_cmp++;
                        if (fn_w[r] !== exp_w[r] || fn_n[r] !== exp_n[r]) begin
                            n_err++;
                            $display("FAIL busy_start_row%0d: got %h/%h, want %h/%h", r, fn_w[r], fn_n[r], exp_w[r], exp_n[r]);
                        end
                    end
                    n_cmp++;
                    if (pop_w !== epop_w || gen_w !== exp_gen) begin
                        n_err++;
                        $display("FAIL busy_start_counts: pop %0d gen %0d, want %0d %0d", pop_w, gen_w, epop_w, exp_gen);
                    end
                end
            end
        end
        n_cmp++;
        if (n_vld !== 1 || first !== LAT) begin
            n_err++;
            $display("FAIL busy_start_vld: %0d strobes first at %0d, want 1 at %0d", n_vld, first, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int n_vld, lat;
        rand_fin();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({vld_w, vld_n, busy_w, busy_n} !== 4'b0 || pop_w !== '0 || gen_w !== 16'd0 || gen_n !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: vld/busy %b pop %0d gen %0d/%0d, want 0",
                     {vld_w, vld_n, busy_w, busy_n}, pop_w, gen_w, gen_n);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== '0 || fn_n[r] !== '0) begin
                n_err++;
                $display("FAIL midreset_row%0d: got %h/%h, want 0", r, fn_w[r], fn_n[r]);
            end
        end
        rst = 1'b1;
        exp_gen = 16'd0;
        n_vld = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (vld_w === 1'b1 || vld_n === 1'b1) n_vld++;
        end
        n_cmp++;
        if (n_vld !== 0) begin
            n_err++;
            $display("FAIL midreset_no_vld: %0d strobes, want 0", n_vld);
        end
        rand_fin();
        do_step(lat);
        n_cmp++;
        if (lat !== LAT || gen_w !== 16'd1 || gen_n !== 16'd1 || pop_w !== epop_w || pop_n !== epop_n) begin
            n_err++;
            $display("FAIL midreset_restart: lat %0d gen %0d/%0d pop %0d/%0d, want %0d 1 %0d/%0d",
                     lat, gen_w, gen_n, pop_w, pop_n, LAT, epop_w, epop_n);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== exp_w[r] || fn_n[r] !== exp_n[r]) begin
                n_err++;
                $display("FAIL midreset_row%0d_after: got %h/%h, want %h/%h", r, fn_w[r], fn_n[r], exp_w[r], exp_n[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        rand_fin();
        do_step(lat);
        n_cmp++;
        if (lat !== LAT || pop_w !== epop_w) begin
            n_err++;
            $display("FAIL b2b_first: lat %0d pop %0d, want %0d %0d", lat, pop_w, LAT, epop_w);
        end
        // Request the next step in the vld cycle itself.
        rand_fin();
        ref_step();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_gen++;
        n_cmp++;
        if (vld_w !== 1'b0 || busy_w !== 1'b1 || busy_n !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: vld %b busy %b/%b, want 0 1/1", vld_w, busy_w, busy_n);
        end
        lat = 0;
        while (vld_w !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== LAT || pop_w !== epop_w || pop_n !== epop_n || gen_w !== exp_gen) begin
            n_err++;
            $display("FAIL b2b_second: lat %0d pop %0d/%0d gen %0d, want %0d %0d/%0d %0d",
                     lat, pop_w, pop_n, gen_w, LAT, epop_w, epop_n, exp_gen);
        end
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (fn_w[r] !== exp_w[r] || fn_n[r] !== exp_n[r]) begin
                n_err++;
                $display("FAIL b2b_row%0d: got %h/%h, want %h/%h", r, fn_w[r], fn_n[r], exp_w[r], exp_n[r]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_gen = 16'd0;
        rst = 1'b0;
        start = 1'b0;
        clear_fin();
        test_reset();
        test_blinker();
        test_block();
        test_all_ones();
        test_glider();
        test_random();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
